// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard controller:
//   - the E0 (extended) and F0 (break) prefix byte values
//   - the decoder state encoding
//   - the 10-bit key event record {ext, brk, code} held in the event FIFO
//   - scan codes of the modifier keys (used when PS2_KEY_MODS_EN is defined)
//   - a parity helper for the frame receiver
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Modifier scan codes. Left/right GUI share the E0 prefix; ctrl and alt
    // use the same code for both sides and are told apart by the E0 prefix.
    localparam logic [7:0] PS2_SC_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_SC_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_SC_CTRL   = 8'h14;
    localparam logic [7:0] PS2_SC_ALT    = 8'h11;
    localparam logic [7:0] PS2_SC_LGUI   = 8'h1F;
    localparam logic [7:0] PS2_SC_RGUI   = 8'h27;

    // Prefix decoder states.
    typedef enum logic [1:0] {
        DEC_IDLE     = 2'd0,
        DEC_GOT_E0   = 2'd1,
        DEC_GOT_F0   = 2'd2,
        DEC_GOT_E0F0 = 2'd3
    } dec_state_e;

    // One key event as stored in the FIFO.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_evt_t;

    // PS/2 uses odd parity: data bits plus the parity bit hold an odd
    // number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data,
                                           input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
// Oversampling PS/2 frame receiver in the clk domain.
//   clk, rst    : system clock, synchronous active-high reset
//   ps2_clk     : raw PS/2 clock (asynchronous, double-flopped here)
//   ps2_data    : raw PS/2 data  (asynchronous, double-flopped here)
//   byte_valid  : one-cycle pulse, rx_byte holds a correctly framed byte
//   rx_byte     : received data byte
//   frame_err   : one-cycle pulse on start/parity/stop error or timeout
//   busy        : a frame is in progress (start bit seen, stop not yet)
// Frame: start(0), 8 data bits LSB first, odd parity, stop(1); every bit is
// taken on a falling edge of the synchronised ps2_clk.
// ----------------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic            clk_s1_q, clk_s1_d;
    logic            clk_s2_q, clk_s2_d;
    logic            clk_s3_q, clk_s3_d;
    logic            data_s1_q, data_s1_d;
    logic            data_s2_q, data_s2_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            busy_q, busy_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            fall;

    // clk_s3 is the previous cycle's synchronised clock, so a 1->0 step
    // between the last two synchronised samples marks a falling edge.
    assign fall = clk_s3_q & ~clk_s2_q;

    // Deserializer and timeout. The bit counter runs 0..10; 0 means idle
    // and waiting for a start bit. A bad start bit reports an error but
    // leaves the counter at 0 so the next edge is again treated as a start.
    always_comb begin
        clk_s1_d     = ps2_clk;
        clk_s2_d     = clk_s1_q;
        clk_s3_d     = clk_s2_q;
        data_s1_d    = ps2_data;
        data_s2_d    = data_s1_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        busy_d       = busy_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        to_cnt_d     = busy_q ? (to_cnt_q + 1'b1) : '0;

        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd0) begin
                if (data_s2_q) begin
                    frame_err_d = 1'b1;
                end else begin
                    bit_cnt_d = 4'd1;
                    busy_d    = 1'b1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {data_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                par_d     = data_s2_q;
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                busy_d    = 1'b0;
                if (ps2_parity_ok(shift_q, par_q) && data_s2_q) begin
                    byte_valid_d = 1'b1;
                    byte_d       = shift_q;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else if (busy_q && (to_cnt_q == TO_LIMIT)) begin
            bit_cnt_d   = 4'd0;
            busy_d      = 1'b0;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end
    end

    // Synchronisers reset to 1 (idle line level) so reset release cannot
    // look like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_s3_q     <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            busy_q       <= 1'b0;
            to_cnt_q     <= '0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            clk_s3_q     <= clk_s3_d;
            data_s1_q    <= data_s1_d;
            data_s2_q    <= data_s2_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            busy_q       <= busy_d;
            to_cnt_q     <= to_cnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = byte_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: rtl/ps2_key_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_key_ctrl
// PS/2 keyboard controller: frame receiver, E0/F0 prefix decoder and a
// key-event FIFO with a valid/ready interface.
//   clk, rst      : system clock, synchronous active-high reset
//   ps2_clk/data  : raw PS/2 lines
//   evt_valid     : FIFO head holds an event
//   evt_ready     : consumer takes the head this cycle
//   evt_code      : head scan code
//   evt_ext       : head had an E0 prefix
//   evt_brk       : head is a break (F0 prefix)
//   frame_err     : one-cycle pulse on a bad or timed-out frame
//   overflow      : sticky, an event was dropped on a full FIFO
//   ovf_clr       : clears overflow (a simultaneous drop wins)
//   busy          : receiver is mid-frame
//   mods[3:0]     : {gui, alt, ctrl, shift}, only with PS2_KEY_MODS_EN
// Optional feature macro: PS2_KEY_MODS_EN (modifier tracking output).
// ----------------------------------------------------------------------------
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       busy
`ifdef PS2_KEY_MODS_EN
    ,
    output logic [3:0] mods
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       rx_busy;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (rx_err),
        .busy      (rx_busy)
    );

    assign frame_err = rx_err;
    assign busy      = rx_busy;

    dec_state_e     state_q, state_d;
    logic           push_q, push_d;
    key_evt_t       push_evt_q, push_evt_d;

    // Prefix decoder. Prefix bytes only move the state; every other byte
    // produces exactly one event, tagged by the prefixes seen before it.
    // In GOT_F0 an E0 is taken as an ordinary code (break of code E0).
    always_comb begin
        state_d    = state_q;
        push_d     = 1'b0;
        push_evt_d = push_evt_q;

        if (rx_err) begin
            state_d = DEC_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    if (rx_byte == PS2_PFX_EXT) begin
                        state_d = DEC_GOT_E0;
                    end else if (rx_byte == PS2_PFX_BRK) begin
                        state_d = DEC_GOT_F0;
                    end else begin
                        push_d          = 1'b1;
                        push_evt_d.ext  = 1'b0;
                        push_evt_d.brk  = 1'b0;
                        push_evt_d.code = rx_byte;
                    end
                end
                DEC_GOT_E0: begin
                    if (rx_byte == PS2_PFX_BRK) begin
                        state_d = DEC_GOT_E0F0;
                    end else if (rx_byte != PS2_PFX_EXT) begin
                        push_d          = 1'b1;
                        push_evt_d.ext  = 1'b1;
                        push_evt_d.brk  = 1'b0;
                        push_evt_d.code = rx_byte;
                        state_d         = DEC_IDLE;
                    end
                end
                DEC_GOT_F0: begin
                    if (rx_byte != PS2_PFX_BRK) begin
                        push_d          = 1'b1;
                        push_evt_d.ext  = 1'b0;
                        push_evt_d.brk  = 1'b1;
                        push_evt_d.code = rx_byte;
                        state_d         = DEC_IDLE;
                    end
                end
                DEC_GOT_E0F0: begin
                    push_d          = 1'b1;
                    push_evt_d.ext  = 1'b1;
                    push_evt_d.brk  = 1'b1;
                    push_evt_d.code = rx_byte;
                    state_d         = DEC_IDLE;
                end
                default: state_d = DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DEC_IDLE;
            push_q     <= 1'b0;
            push_evt_q <= '0;
        end else begin
            state_q    <= state_d;
            push_q     <= push_d;
            push_evt_q <= push_evt_d;
        end
    end

    // Event FIFO. A full FIFO still accepts a push when the head is popped
    // in the same cycle; otherwise the push is dropped and flagged.
    key_evt_t         mem_q [FIFO_DEPTH];
    key_evt_t         head_evt;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             fifo_full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign evt_valid = (count_q != '0);
    assign fifo_full = (count_q == FIFO_FULL);
    assign pop       = evt_valid && evt_ready;
    assign wr_en     = push_q && (!fifo_full || pop);
    assign drop      = push_q && fifo_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q > 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_evt_q;
        end
    end

    assign head_evt = mem_q[rd_ptr_q];
    assign evt_code = evt_valid ? head_evt.code : 8'd0;
    assign evt_ext  = evt_valid ? head_evt.ext  : 1'b0;
    assign evt_brk  = evt_valid ? head_evt.brk  : 1'b0;
    assign overflow = overflow_q;

`ifdef PS2_KEY_MODS_EN
    // Per-key flags: [0] lshift [1] rshift [2] lctrl [3] rctrl
    //                [4] lalt   [5] ralt   [6] lgui  [7] rgui
    // Updated on every decoded event, whether or not the FIFO kept it.
    logic [7:0] mod_flags_q, mod_flags_d;
    logic       mod_set;

    always_comb begin
        mod_flags_d = mod_flags_q;
        mod_set     = ~push_evt_q.brk;
        if (push_q) begin
            if (!push_evt_q.ext && (push_evt_q.code == PS2_SC_LSHIFT)) mod_flags_d[0] = mod_set;
            if (!push_evt_q.ext && (push_evt_q.code == PS2_SC_RSHIFT)) mod_flags_d[1] = mod_set;
            if (!push_evt_q.ext && (push_evt_q.code == PS2_SC_CTRL))   mod_flags_d[2] = mod_set;
            if ( push_evt_q.ext && (push_evt_q.code == PS2_SC_CTRL))   mod_flags_d[3] = mod_set;
            if (!push_evt_q.ext && (push_evt_q.code == PS2_SC_ALT))    mod_flags_d[4] = mod_set;
            if ( push_evt_q.ext && (push_evt_q.code == PS2_SC_ALT))    mod_flags_d[5] = mod_set;
            if ( push_evt_q.ext && (push_evt_q.code == PS2_SC_LGUI))   mod_flags_d[6] = mod_set;
            if ( push_evt_q.ext && (push_evt_q.code == PS2_SC_RGUI))   mod_flags_d[7] = mod_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mod_flags_q <= 8'd0;
        end else begin
            mod_flags_q <= mod_flags_d;
        end
    end

    assign mods = {|mod_flags_q[7:6], |mod_flags_q[5:4],
                   |mod_flags_q[3:2], |mod_flags_q[1:0]};
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_ctrl
// Directed bench for ps2_key_ctrl. Frames are bit-banged on ps2_clk/ps2_data;
// expected events go into a queue when a frame is sent and are compared when
// the DUT hands them over on evt_valid && evt_ready.
// Define PS2_KEY_MODS_EN to also exercise the mods output.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int HALF  = 20;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       evt_ready = 1'b0;
    logic       ovf_clr   = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       frame_err;
    logic       overflow;
    logic       busy;
`ifdef PS2_KEY_MODS_EN
    logic [3:0] mods;
`endif

    ps2_key_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_ext  (evt_ext),
        .evt_brk  (evt_brk),
        .frame_err(frame_err),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .busy     (busy)
`ifdef PS2_KEY_MODS_EN
        ,
        .mods     (mods)
`endif
    );

    always #5 clk = ~clk;

    int         errors     = 0;
    int         checks     = 0;
    int         cyc        = 0;
    int         err_pulses = 0;
    int         err_cyc    = -1;
    int         rise_cyc   = -1;
    int         stop_cyc   = 0;
    int         base_err   = 0;
    logic       valid_prev = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_evt;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor on the falling clk edge: counts frame_err pulses, notes
    // the first cycle of evt_valid, and scores every handed-over event.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) begin
                err_pulses++;
                err_cyc = cyc;
            end
            if (evt_valid && !valid_prev) rise_cyc = cyc;
            if (evt_valid && evt_ready) begin
                checkOutput("evt_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_evt = exp_q.pop_front();
                    checkOutput("evt_data", 32'({evt_ext, evt_brk, evt_code}), 32'(exp_evt));
                end
            end
        end
        valid_prev = evt_valid;
    end

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2Bit(input logic b);
        ps2_data = b;
        waitCycles(HALF);
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic sendHead(input logic [7:0] code, input logic flip);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit((~^code) ^ flip);
    endtask

    task automatic stopFall(input logic b);
        ps2_data = b;
        waitCycles(HALF);
        ps2_clk  = 1'b0;
        stop_cyc = cyc;
    endtask

    task automatic endFrame();
        waitCycles(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        waitCycles(HALF);
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic flip,
                                 input logic stop);
        sendHead(code, flip);
        stopFall(stop);
        endFrame();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(evt_valid), 32'd0);
        checkOutput({tag, "_code"},  32'(evt_code),  32'd0);
        checkOutput({tag, "_ext"},   32'(evt_ext),   32'd0);
        checkOutput({tag, "_brk"},   32'(evt_brk),   32'd0);
        checkOutput({tag, "_ferr"},  32'(frame_err), 32'd0);
        checkOutput({tag, "_ovf"},   32'(overflow),  32'd0);
        checkOutput({tag, "_busy"},  32'(busy),      32'd0);
`ifdef PS2_KEY_MODS_EN
        checkOutput({tag, "_mods"},  32'(mods),      32'd0);
`endif
    endtask

    initial begin
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

        // Reset state
        waitCycles(5);
        checkIdle("reset");
        rst = 1'b0;
        waitCycles(5);
        evt_ready = 1'b1;

        // Single make code with latency check
        base_err = err_pulses;
        rise_cyc = -1;
        exp_q.push_back({2'b00, 8'h1C});
        applyStimulus(8'h1C, 1'b0, 1'b1);
        checkOutput("make_latency", 32'(rise_cyc - stop_cyc), 32'd5);
        checkOutput("make_no_err", 32'(err_pulses - base_err), 32'd0);
        checkOutput("make_drained", 32'(exp_q.size()), 32'd0);

        // Prefix sequences
        exp_q.push_back({2'b01, 8'h1C});
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h1C, 1'b0, 1'b1);
        exp_q.push_back({2'b11, 8'h75});
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        exp_q.push_back({2'b10, 8'h75});
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 1'b1);
        exp_q.push_back({2'b01, 8'hE0});
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'hE0, 1'b0, 1'b1);
        checkOutput("prefix_drained", 32'(exp_q.size()), 32'd0);

        // Parity error, then a good frame
        base_err = err_pulses;
        applyStimulus(8'h1C, 1'b1, 1'b1);
        checkOutput("parity_err_cnt", 32'(err_pulses - base_err), 32'd1);
        checkOutput("parity_err_time", 32'(err_cyc - stop_cyc), 32'd3);
        exp_q.push_back({2'b00, 8'h32});
        applyStimulus(8'h32, 1'b0, 1'b1);
        checkOutput("after_parity_drained", 32'(exp_q.size()), 32'd0);

        // Stop bit error and a start bit sampled high
        base_err = err_pulses;
        applyStimulus(8'h2B, 1'b0, 1'b0);
        checkOutput("stop_err_cnt", 32'(err_pulses - base_err), 32'd1);
        ps2Bit(1'b1);
        waitCycles(5);
        checkOutput("start_err_cnt", 32'(err_pulses - base_err), 32'd2);
        checkOutput("start_err_busy", 32'(busy), 32'd0);

        // Timeout in a partial frame after a pending E0 prefix
        applyStimulus(8'hE0, 1'b0, 1'b1);
        base_err = err_pulses;
        ps2Bit(1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(1'b1);
        checkOutput("partial_busy", 32'(busy), 32'd1);
        waitCycles(TO + 50);
        checkOutput("timeout_err_cnt", 32'(err_pulses - base_err), 32'd1);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        exp_q.push_back({2'b00, 8'h1C});
        applyStimulus(8'h1C, 1'b0, 1'b1);
        checkOutput("after_timeout_drained", 32'(exp_q.size()), 32'd0);

        // Fill FIFO with the consumer stalled; ninth event is dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) exp_q.push_back({2'b00, codes[i]});
            applyStimulus(codes[i], 1'b0, 1'b1);
        end
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_valid", 32'(evt_valid), 32'd1);
        checkOutput("hold_code_a", 32'(evt_code), 32'h15);
        waitCycles(10);
        checkOutput("hold_code_b", 32'(evt_code), 32'h15);
        ovf_clr = 1'b1;
        waitCycles(1);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a pop in the same cycle as the push
        exp_q.push_back({2'b00, 8'h4D});
        sendHead(8'h4D, 1'b0);
        stopFall(1'b1);
        waitCycles(4);
        evt_ready = 1'b1;
        waitCycles(1);
        evt_ready = 1'b0;
        endFrame();
        checkOutput("pop_push_ovf", 32'(overflow), 32'd0);

        // Drop coinciding with ovf_clr: set wins
        sendHead(8'h4E, 1'b0);
        stopFall(1'b1);
        waitCycles(4);
        ovf_clr = 1'b1;
        waitCycles(1);
        ovf_clr = 1'b0;
        checkOutput("set_wins_ovf", 32'(overflow), 32'd1);
        endFrame();
        evt_ready = 1'b1;
        waitCycles(20);
        checkOutput("full_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("full_empty_valid", 32'(evt_valid), 32'd0);
        ovf_clr = 1'b1;
        waitCycles(1);
        ovf_clr = 1'b0;

`ifdef PS2_KEY_MODS_EN
        // Modifier tracking
        exp_q.push_back({2'b00, 8'h12});
        applyStimulus(8'h12, 1'b0, 1'b1);
        checkOutput("mods_lshift", 32'(mods), 32'h1);
        exp_q.push_back({2'b00, 8'h59});
        applyStimulus(8'h59, 1'b0, 1'b1);
        exp_q.push_back({2'b01, 8'h12});
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h12, 1'b0, 1'b1);
        checkOutput("mods_rshift_held", 32'(mods), 32'h1);
        exp_q.push_back({2'b01, 8'h59});
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h59, 1'b0, 1'b1);
        checkOutput("mods_released", 32'(mods), 32'h0);
        exp_q.push_back({2'b10, 8'h14});
        applyStimulus(8'hE0, 1'b0, 1'b1);
        applyStimulus(8'h14, 1'b0, 1'b1);
        checkOutput("mods_rctrl", 32'(mods), 32'h2);
`endif

        // Reset mid-frame with events queued and a pending F0 prefix
        evt_ready = 1'b0;
        applyStimulus(8'h1C, 1'b0, 1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        rst = 1'b1;
        waitCycles(2);
        checkIdle("midrst");
        exp_q.delete();
        rst = 1'b0;
        waitCycles(5);
        evt_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        applyStimulus(8'h1C, 1'b0, 1'b1);
        checkOutput("after_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net in case something stalls.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
System-clock-domain controller for the DE2 PS/2 keyboard path. Oversamples ps2_clk/ps2_data, frames 11-bit PS/2 packets with full start/parity/stop checking, and sequences the E0/F0 prefix protocol. Emits one key event per make/break through a small FIFO with a valid/ready handshake. Feeds the VGA text/console logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts head this cycle
evt_code  out  8  scan code of head event
evt_ext  out  1  head event carried E0 prefix
evt_brk  out  1  head event is a break (F0 prefix)
frame_err  out  1  one-cycle pulse on start/parity/stop error or timeout
overflow  out  1  sticky: an event was dropped because FIFO full
ovf_clr  in  1  clears overflow
busy  out  1  frame receiver mid-frame

Behaviour:
- Reset: synchronous, active-high on clk; evt_valid=0, evt_code=0, evt_ext=0, evt_brk=0, frame_err=0, overflow=0, busy=0; FIFO empty; decoder in IDLE; bit counter 0. rst mid-frame discards the partial frame and any pending prefix.
- Input sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is synced ps2_clk 1->0 between consecutive cycles; data is sampled from the synced ps2_data on that cycle.
- Frame receiver: bit 0 start (must be 0), bits 1-8 data LSB first, bit 9 odd parity over data+parity, bit 10 stop (must be 1). busy=1 from the start-bit edge until the frame ends.
- Start bit sampled as 1: frame_err pulse, count stays 0 (resync).
- At the stop-bit edge (cycle T): on parity or stop error, frame_err pulses at T+1 and no byte is produced. Otherwise byte_valid pulses at T+1.
- Timeout: a counter resets on every falling edge. If busy and the counter reaches TIMEOUT_CYCLES, the frame aborts, frame_err pulses, busy=0, and the decoder returns to IDLE.
- Decoder FSM (advances only on byte_valid): IDLE, GOT_E0, GOT_F0, GOT_E0F0.
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0; other byte b -> push {ext=0, brk=0, b}, stay IDLE.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> stay; other b -> push {1,0,b}, -> IDLE.
  - GOT_F0: F0 -> stay; other b (including E0) -> push {0,1,b}, -> IDLE.
  - GOT_E0F0: any b -> push {1,1,b}, -> IDLE.
  - Any frame_err -> IDLE.
- Push is registered: FIFO write at T+2, evt_valid high at T+3 if FIFO was empty.
- FIFO: 10-bit entries {ext, brk, code}. Head is on the evt_* outputs. Pop when evt_valid && evt_ready. Outputs hold stable while evt_valid && !evt_ready.
- FIFO full: if full with no pop that cycle, the push is dropped and overflow is set. If full and pop occur in the same cycle, the push is accepted. If empty, a push and evt_ready in the same cycle does not pop (evt_valid was 0).
- ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.

Optional Feature:
Macro PS2_KEY_MODS_EN. When defined, adds output mods[3:0] = {gui, alt, ctrl, shift}, reset 0000, updated when an event is pushed, independent of FIFO full.
- shift: codes 12/59, ext=0.
- ctrl: code 14, either ext value.
- alt: code 11, either ext value.
- gui: codes E0 1F / E0 27.
- Make sets the bit; break clears it. Left and right keys are OR-ed via per-key internal flags.
Without the macro, the port and logic are absent and event behaviour is identical.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0;
  - decoder state enum;
  - the 10-bit key-event struct {ext, brk, code};
  - modifier scan-code constants.
- Sub-module ps2_rx_frame (sync, edge detect, deserializer, parity, timeout) outputs byte_valid/byte/frame_err/busy. The decoder FSM and FIFO stay in ps2_key_ctrl.

Test Plan:
- Frame 1C, good parity, evt_ready=1 -> one event {0,0,1C} at T+3; frame_err stays 0.
- Frames F0,1C -> single event {0,1,1C}. Frames E0,F0,75 -> single event {1,1,75}. No event for prefix bytes.
- Frame 1C with parity bit flipped -> frame_err pulse at T+1, no event. Next good frame 32 -> event {0,0,32}.
- Send 5 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err, busy=0. Following good frame 1C decoded correctly.
- evt_ready=0 and 9 make codes with FIFO_DEPTH=8 -> 8 events kept in order, 9th dropped, overflow=1. ovf_clr clears it. Full with simultaneous pop -> push accepted.
- PS2_KEY_MODS_EN: 12 make -> mods=0001. 59 make, then 12 break -> still 0001. 59 break -> 0000. rst mid-frame -> all outputs zero.
